// File: rtl/mem_arb_pkg.sv
// Shared types and AddrMode encodings for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  localparam logic [3:0] LB   = 4'b0000;
  localparam logic [3:0] LH   = 4'b0001;
  localparam logic [3:0] LW   = 4'b0010;
  localparam logic [3:0] LBU  = 4'b0011;
  localparam logic [3:0] LHU  = 4'b0100;
  localparam logic [3:0] SB   = 4'b0101;
  localparam logic [3:0] SH   = 4'b0110;
  localparam logic [3:0] SW   = 4'b0111;
  localparam logic [3:0] NONE = 4'b1000;

  function automatic logic is_store(input logic [3:0] mode);
    return (mode == SB) || (mode == SH) || (mode == SW);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog counter for an outstanding memory access; expired flags TIMEOUT-1 waited cycles.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expired = (cnt_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between fetch and load/store.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_addrmode,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  err,
  output logic                  if_stall,
  output logic                  d_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_addrmode,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  state_e state_reg, state_next;
  grant_e grant_reg, grant_next, last_grant_reg;

  logic                  mem_req_reg, mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [3:0]            mem_addrmode_reg;
  logic                  if_ack_reg, d_ack_reg, err_reg;
  logic [DATA_WIDTH-1:0] if_rdata_reg, d_rdata_reg;

  logic do_grant, done_ok, done_to, expired;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (do_grant),
    .enable  ((state_reg == BUSY) && !mem_ready && !expired),
    .expired (expired)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    do_grant   = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req || d_req) begin
          do_grant   = 1'b1;
          state_next = BUSY;
          // On a tie the requester not served last time wins.
          if (if_req && d_req) begin
            grant_next = (last_grant_reg == GNT_IF) ? GNT_D : GNT_IF;
          end else begin
            grant_next = d_req ? GNT_D : GNT_IF;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (expired) begin
          done_to    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      grant_reg        <= GNT_IF;
      last_grant_reg   <= GNT_IF;
      mem_req_reg      <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wdata_reg    <= '0;
      mem_addrmode_reg <= NONE;
      if_ack_reg       <= 1'b0;
      d_ack_reg        <= 1'b0;
      err_reg          <= 1'b0;
      if_rdata_reg     <= '0;
      d_rdata_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      if_ack_reg <= 1'b0;
      d_ack_reg  <= 1'b0;
      if (do_grant) begin
        mem_req_reg      <= 1'b1;
        mem_addr_reg     <= (grant_next == GNT_D) ? d_addr : if_addr;
        mem_wdata_reg    <= (grant_next == GNT_D) ? d_wdata : '0;
        mem_addrmode_reg <= (grant_next == GNT_D) ? d_addrmode : LW;
        mem_we_reg       <= (grant_next == GNT_D) && is_store(d_addrmode);
      end
      if (done_ok || done_to) begin
        mem_req_reg <= 1'b0;
        mem_we_reg  <= 1'b0;
        err_reg     <= done_to;
        // A timed-out access leaves the requester's rdata untouched.
        if (grant_reg == GNT_D) begin
          d_ack_reg <= 1'b1;
          if (done_ok) d_rdata_reg <= mem_rdata;
        end else begin
          if_ack_reg <= 1'b1;
          if (done_ok) if_rdata_reg <= mem_rdata;
        end
      end
      if (state_reg == RESP) begin
        last_grant_reg <= grant_reg;
        err_reg        <= 1'b0;
      end
    end
  end

  logic [1:0] req_vec, ack_vec, stall_vec;

  assign req_vec = {d_req, if_req};
  assign ack_vec = {d_ack_reg, if_ack_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stall
      assign stall_vec[gi] = req_vec[gi] & ~ack_vec[gi];
    end
  endgenerate

  assign if_stall     = stall_vec[0];
  assign d_stall      = stall_vec[1];
  assign if_ack       = if_ack_reg;
  assign d_ack        = d_ack_reg;
  assign if_rdata     = if_rdata_reg;
  assign d_rdata      = d_rdata_reg;
  assign err          = err_reg;
  assign mem_req      = mem_req_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign mem_addrmode = mem_addrmode_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small latency-programmable memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_addrmode;
  logic        if_ack, d_ack, err, if_stall, d_stall;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_addrmode;

  int n_checks = 0;
  int n_fails  = 0;

  // memory model controls
  int          mem_lat    = 0;
  bit          mem_dead   = 1'b0;
  bit          fixed_en   = 1'b0;
  logic [31:0] fixed_data = '0;
  int          busy_cnt   = 0;

  // last values seen on the memory side while mem_req was high
  logic        obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_mode;
  int          if_ack_cnt = 0;
  int          d_ack_cnt  = 0;
  logic        if_stall_q = 1'b0;
  logic        d_stall_q  = 1'b0;

  mem_port_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .TIMEOUT    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ack       (if_ack),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_addrmode   (d_addrmode),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .err          (err),
    .if_stall     (if_stall),
    .d_stall      (d_stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addrmode (mem_addrmode),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Memory: ready in the (mem_lat+1)-th cycle of mem_req, never when mem_dead.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_ready = !mem_dead && (busy_cnt == mem_lat);
        mem_rdata = fixed_en ? fixed_data : (mem_addr ^ KEY);
        busy_cnt++;
      end else begin
        busy_cnt  = 0;
        mem_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req) begin
      obs_we    <= mem_we;
      obs_addr  <= mem_addr;
      obs_wdata <= mem_wdata;
      obs_mode  <= mem_addrmode;
    end
    if (if_ack) if_ack_cnt <= if_ack_cnt + 1;
    if (d_ack)  d_ack_cnt  <= d_ack_cnt + 1;
  end

  // Requesters must hold req while stalled.
  always @(posedge clk) begin
    if (rst_n && if_stall_q) assert (if_req) else $error("if_req dropped before if_ack");
    if (rst_n && d_stall_q)  assert (d_req)  else $error("d_req dropped before d_ack");
    if_stall_q <= if_stall && rst_n;
    d_stall_q  <= d_stall && rst_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access; lat counts cycles from the request cycle (0) to the ack cycle.
  task automatic run_access(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mode, output int lat, output logic [31:0] rd,
                            output logic e, output logic stall0, output logic ack_after);
    @(posedge clk);
    #1;
    if (is_d) begin
      d_req = 1'b1; d_addr = addr; d_wdata = wdata; d_addrmode = mode;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1; rd = '0; e = 1'b0; stall0 = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      if (t == 0) stall0 = is_d ? d_stall : if_stall;
      if (is_d ? d_ack : if_ack) begin
        lat = t;
        rd  = is_d ? d_rdata : if_rdata;
        e   = err;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    ack_after = is_d ? d_ack : if_ack;
    $display("txn %s addr=0x%08h mode=%0d lat=%0d rdata=0x%08h err=%0b",
             is_d ? "data " : "fetch", addr, mode, lat, rd, e);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        e, st0, ack_after;
  int          acks_before;
  bit          who_d;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_addrmode = NONE;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addrmode", 32'(mem_addrmode), 32'(NONE));
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stalls", {30'd0, if_stall, d_stall}, 32'd0);

    // single fetch, memory ready 3 cycles after mem_req
    mem_lat = 3; fixed_en = 1'b1; fixed_data = 32'hDEAD_BEEF;
    run_access(1'b0, 32'h100, 32'h0, NONE, lat, rd, e, st0, ack_after);
    chk("fetch_stall0", 32'(st0), 32'd1);
    chk("fetch_lat", 32'(lat), 32'd5);
    chk("fetch_rdata", rd, 32'hDEAD_BEEF);
    chk("fetch_err", 32'(e), 32'd0);
    chk("fetch_we", 32'(obs_we), 32'd0);
    chk("fetch_mode", 32'(obs_mode), 32'(LW));
    chk("fetch_addr", obs_addr, 32'h100);
    chk("fetch_ack_pulse", 32'(ack_after), 32'd0);
    fixed_en = 1'b0;

    // zero-wait store
    mem_lat = 0;
    run_access(1'b1, 32'h200, 32'h1234_5678, SW, lat, rd, e, st0, ack_after);
    chk("store_lat", 32'(lat), 32'd2);
    chk("store_we", 32'(obs_we), 32'd1);
    chk("store_addr", obs_addr, 32'h200);
    chk("store_wdata", obs_wdata, 32'h1234_5678);
    chk("store_mode", 32'(obs_mode), 32'(SW));
    chk("store_err", 32'(e), 32'd0);

    // both requesting from reset: D, IF, D, IF, then the still-pending D
    apply_reset();
    mem_lat = 1;
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h400; d_wdata = '0; d_addrmode = LW;
    for (int i = 0; i < 5; i++) begin
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (if_ack || d_ack) break;
      end
      chk("rr_ack_seen", 32'(if_ack | d_ack), 32'd1);
      who_d = d_ack;
      chk("rr_order", 32'(who_d), 32'((i % 2) == 0));
      chk("rr_rdata", who_d ? d_rdata : if_rdata, (who_d ? 32'h400 : 32'h300) ^ KEY);
      if (i < 4) chk("rr_other_stall", 32'(who_d ? if_stall : d_stall), 32'd1);
      $display("txn rr access=%0d granted=%s if_stall=%0b d_stall=%0b",
               i, who_d ? "data" : "fetch", if_stall, d_stall);
      if (i == 3) begin
        @(posedge clk);
        #1;
        if_req = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;

    // timeout: never ready, err ack at cycle TIMEOUT+1, rdata untouched
    mem_dead = 1'b1;
    run_access(1'b0, 32'h500, 32'h0, NONE, lat, rd, e, st0, ack_after);
    chk("to_lat", 32'(lat), 32'd9);
    chk("to_err", 32'(e), 32'd1);
    chk("to_rdata_kept", rd, 32'h300 ^ KEY);
    mem_dead = 1'b0;
    mem_lat  = 0;
    run_access(1'b0, 32'h600, 32'h0, NONE, lat, rd, e, st0, ack_after);
    chk("after_to_lat", 32'(lat), 32'd2);
    chk("after_to_err", 32'(e), 32'd0);
    chk("after_to_rdata", rd, 32'h600 ^ KEY);

    // reset in the middle of BUSY
    mem_dead = 1'b1;
    @(posedge clk);
    #1;
    d_req = 1'b1; d_addr = 32'h700; d_addrmode = LW;
    repeat (3) @(negedge clk);
    chk("midrst_busy", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mode", 32'(mem_addrmode), 32'(NONE));
    chk("midrst_addr", mem_addr, 32'd0);
    acks_before = if_ack_cnt + d_ack_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_dead = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_ack", 32'(if_ack_cnt + d_ack_cnt), 32'(acks_before));
    chk("midrst_d_rdata", d_rdata, 32'd0);
    $display("txn reset-abort addr=0x00000700 acks_after_release=%0d",
             if_ack_cnt + d_ack_cnt - acks_before);
    mem_lat = 2;
    run_access(1'b0, 32'h800, 32'h0, NONE, lat, rd, e, st0, ack_after);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_rdata", rd, 32'h800 ^ KEY);

    // AddrMode NONE data access
    mem_lat = 0;
    run_access(1'b1, 32'h900, 32'hCAFE_F00D, NONE, lat, rd, e, st0, ack_after);
    chk("none_lat", 32'(lat), 32'd2);
    chk("none_we", 32'(obs_we), 32'd0);
    chk("none_mode", 32'(obs_mode), 32'(NONE));
    chk("none_rdata", rd, 32'h900 ^ KEY);
    chk("none_ack_pulse", 32'(ack_after), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-port, variable-latency memory between the instruction-fetch requester and the data (load/store) requester. It sits between the fetch/LSU stages and the unified memory. It serialises accesses with a round-robin grant and a request/ack handshake, and translates the data-side AddrMode into the memory's write enable. A watchdog returns an error ack if memory never responds.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- TIMEOUT, 64, max cycles waiting for mem_ready before error ack (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched word (registered)
- d_req  in  1  data request; held with d_addr, d_wdata and d_addrmode stable until d_ack
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_addrmode  in  4  AddrMode encoding: 0000–0100 are loads, 0101–0111 are stores, 1000 is none
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_WIDTH  load data (registered)
- err  out  1  valid with an ack pulse: access timed out
- if_stall, d_stall  out  1  each equals its req & ~ack (combinational)
- mem_req  out  1  memory request, registered
- mem_we  out  1  high when the granted data access is a store
- mem_addr  out  ADDR_WIDTH  granted address
- mem_wdata  out  DATA_WIDTH  granted store data
- mem_addrmode  out  4  fetch drives 0010 (lw); data passes d_addrmode through
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_ready  in  1  memory completes the access this cycle

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester opposite to last_grant.
  - On a grant, latch address, wdata and mode into the output registers, set mem_req, clear the watchdog counter, and go to BUSY.
- **BUSY**
  - mem_req held high with stable outputs.
  - mem_ready=1: capture mem_rdata into the granted requester's rdata register, set err=0, and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without mem_ready, set err=1, leave rdata unchanged, and go to RESP.
  - mem_req drops on entry to RESP.
- **RESP**
  - Pulse the granted requester's ack for exactly one cycle.
  - Update last_grant to the served requester.
  - Go to IDLE. New requests are not sampled in RESP.
- mem_we = 1 only for a data grant with mode in 0101–0111. A d_addrmode of 1000 is forwarded unchanged with mem_we=0.
- The non-granted request waits with no loss; its stall stays high.
- Reset (asynchronous, any state):
  - state is IDLE.
  - mem_req, mem_we, both acks and err are 0.
  - mem_addr, mem_wdata and both rdata registers are 0.
  - mem_addrmode is 1000.
  - last_grant is fetch, so the first tie goes to data.
- Reset during BUSY abandons the access; the memory is expected to be reset alongside.

## Timing
- Request seen in IDLE at cycle 0: mem_req high from cycle 1.
- mem_ready at cycle k ≥ 1: ack and rdata valid at cycle k+1; IDLE at k+2.
- Minimum latency is req→ack of 2 cycles. Peak throughput is one access per 3 cycles.
- Timeout: with mem_req high from cycle 1 and no mem_ready, the err ack arrives at cycle TIMEOUT+1.
- mem_ready arriving outside BUSY is ignored.
- A requester deasserting req before its ack violates the protocol; behaviour is undefined and the bench asserts against it.

## Structure
- mem_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - grant enum {GNT_IF, GNT_D}
  - AddrMode localparams: LB=0000, LH=0001, LW=0010, LBU=0011, LHU=0100, SB=0101, SH=0110, SW=0111, NONE=1000
  - is_store() helper function
- Sub-module mem_timeout_ctr: clear/enable inputs, expired output at TIMEOUT-1, $clog2(TIMEOUT) bits wide.

## Test plan
- Single fetch, addr 0x100, mem_ready 3 cycles after mem_req with rdata 0xDEADBEEF → if_ack pulses once at the expected cycle, if_rdata=0xDEADBEEF, mem_we=0, mem_addrmode=0010, err=0.
- Store: d_addrmode=0111, addr 0x200, wdata 0x12345678, zero-wait memory → mem_we=1, mem_addr/mem_wdata correct, d_ack 2 cycles after req.
- Both requesting from reset for 4 accesses → grants in order D, IF, D, IF; each stall stays high until its own ack.
- Memory never ready, TIMEOUT=8 → ack with err=1 at cycle 9, rdata unchanged, then the next request is served normally.
- rst_n low mid-BUSY → mem_req=0, mem_addrmode=1000 immediately; no ack after release; a fresh request then completes.
- d_addrmode=1000 data request → forwarded with mem_we=0; d_ack still pulses.
